// File: rtl/prio_arbiter_4ch_pkg.sv
// Shared types and helpers for the 4-channel priority arbiter.
// Optional round-robin search order: PRIO_ARB_ROUND_ROBIN_EN.
package prio_arb_pkg;

    localparam int NUM_CH = 4;
    localparam int ID_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic logic [NUM_CH-1:0] id_onehot(
        input logic [ID_W-1:0] id
    );
        logic [NUM_CH-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/prio_arbiter_4ch_if.sv
// Request/grant bundle between requesters and the arbiter.
// master drives requests; slave is the arbiter side.
interface prio_arbiter_4ch_if;
    import prio_arb_pkg::*;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic [ID_W-1:0]   gnt_id;
    logic              gnt_valid;
    logic              preempt;

    modport master (
        output req,
        input  gnt,
        input  gnt_id,
        input  gnt_valid,
        input  preempt
    );

    modport slave (
        input  req,
        output gnt,
        output gnt_id,
        output gnt_valid,
        output preempt
    );

endinterface

// File: rtl/prio_arbiter_4ch_pick4.sv
// Combinational winner pick: rotate, encode 3-downto-0, rotate back.
// An offset of 0 gives plain fixed priority 3 > 2 > 1 > 0.
module prio_pick4
    import prio_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [ID_W-1:0]   offset,
    output logic [ID_W-1:0]   id,
    output logic              found
);

    logic [2*NUM_CH-1:0] dbl;
    logic [NUM_CH-1:0]   rot;
    logic [ID_W-1:0]     rid;

    always_comb begin
        dbl   = {req, req} >> offset;
        rot   = dbl[NUM_CH-1:0];
        rid   = '0;
        found = 1'b1;
        priority casez (rot)
            4'b1???: rid = 2'd3;
            4'b01??: rid = 2'd2;
            4'b001?: rid = 2'd1;
            4'b0001: rid = 2'd0;
            default: found = 1'b0;
        endcase
        id = rid + offset;
    end

endmodule

// File: rtl/prio_arbiter_4ch.sv
// 4-channel arbiter with registered grants and hold-timeout preemption.
// Define PRIO_ARB_ROUND_ROBIN_EN for rotating search order.
module prio_arbiter_4ch
    import prio_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int CNT_W    = 4
) (
    input logic               clk,
    input logic               rst,
    prio_arbiter_4ch_if.slave bus
);

    localparam logic [CNT_W-1:0] HOLD_LAST =
        (MAX_HOLD == 0) ? {CNT_W{1'b1}}
                        : CNT_W'(MAX_HOLD - 1);

    arb_state_t        state;
    logic [CNT_W-1:0]  hold_cnt;
    logic [NUM_CH-1:0] gnt_q;
    logic [ID_W-1:0]   id_q;
    logic              valid_q;
    logic              pre_q;

    logic              owner_req;
    logic              others;
    logic              timeout;
    logic [NUM_CH-1:0] pick_req;
    logic [ID_W-1:0]   offset;
    logic [ID_W-1:0]   win;
    logic              found;

`ifdef PRIO_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0]   rr_ptr;
    assign offset = rr_ptr;
`else
    assign offset = '0;
`endif

    // gnt_q is zero when idle, so masking it out is always safe
    assign owner_req = |(bus.req & gnt_q);
    assign pick_req  = bus.req & ~gnt_q;
    assign others    = |pick_req;
    assign timeout   = (MAX_HOLD != 0)
                    && (hold_cnt == HOLD_LAST)
                    && owner_req && others;

    prio_pick4 u_pick (
        .req    (pick_req),
        .offset (offset),
        .id     (win),
        .found  (found)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            gnt_q    <= '0;
            id_q     <= '0;
            valid_q  <= 1'b0;
            pre_q    <= 1'b0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
            rr_ptr   <= '0;
`endif
        end else begin
            pre_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state    <= BUSY;
                        gnt_q    <= id_onehot(win);
                        id_q     <= win;
                        valid_q  <= 1'b1;
                        hold_cnt <= '0;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                        rr_ptr   <= win;
`endif
                    end
                end
                BUSY: begin
                    if (!owner_req || timeout) begin
                        if (found) begin
                            gnt_q    <= id_onehot(win);
                            id_q     <= win;
                            valid_q  <= 1'b1;
                            hold_cnt <= '0;
                            pre_q    <= owner_req;
`ifdef PRIO_ARB_ROUND_ROBIN_EN
                            rr_ptr   <= win;
`endif
                        end else begin
                            state    <= IDLE;
                            gnt_q    <= '0;
                            id_q     <= '0;
                            valid_q  <= 1'b0;
                            hold_cnt <= '0;
                        end
                    end else if (hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = id_q;
    assign bus.gnt_valid = valid_q;
    assign bus.preempt   = pre_q;

endmodule

// File: tb/tb_prio_arbiter_4ch.sv
// Bench: two arbiters (hold 8 and hold 2) against a behavioural model.
// Directed literal checks plus randomized request traffic.
module tb_prio_arbiter_4ch;

    logic       clk;
    logic       rst;
    logic [3:0] req;

    int n_cmp = 0;
    int n_bad = 0;

    prio_arbiter_4ch_if bus8 ();
    prio_arbiter_4ch_if bus2 ();

    assign bus8.req = req;
    assign bus2.req = req;

    prio_arbiter_4ch #(.MAX_HOLD(8), .CNT_W(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8.slave)
    );

    prio_arbiter_4ch #(.MAX_HOLD(2), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input int exp);
        n_cmp++;
        if (act !== 32'(exp)) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    // Model: owner index (-1 none), cycles visible, last grantee
    int m_owner [2];
    int m_held  [2];
    int m_rr    [2];
    int m_pre   [2];
    int m_hold  [2] = '{8, 2};

    function automatic int pick(input logic [3:0] r,
                                input int excl,
                                input int k);
        for (int s = 1; s <= 4; s++) begin
            int c;
            c = ((k - s) % 4 + 4) % 4;
            if (r[c] && c != excl) return c;
        end
        return -1;
    endfunction

    function automatic int order_base(input int d);
`ifdef PRIO_ARB_ROUND_ROBIN_EN
        return m_rr[d];
`else
        return 0 * d;
`endif
    endfunction

    task automatic model_step(input int d);
        int w;
        int o;
        logic [3:0] oth;
        if (rst) begin
            m_owner[d] = -1;
            m_held[d]  = 0;
            m_rr[d]    = 0;
            m_pre[d]   = 0;
            return;
        end
        m_pre[d] = 0;
        o = m_owner[d];
        if (o < 0 || !req[o]) begin
            w = pick(req, -1, order_base(d));
            m_owner[d] = w;
            m_held[d]  = (w >= 0) ? 1 : 0;
            if (w >= 0) m_rr[d] = w;
        end else begin
            oth    = req;
            oth[o] = 1'b0;
            if (m_hold[d] != 0 && m_held[d] >= m_hold[d]
                && oth != 4'b0) begin
                w = pick(req, o, order_base(d));
                m_owner[d] = w;
                m_held[d]  = 1;
                m_rr[d]    = w;
                m_pre[d]   = 1;
            end else begin
                m_held[d]++;
            end
        end
    endtask

    task automatic model_cmp(input int d,
                             input logic [3:0] g,
                             input logic [1:0] id,
                             input logic v,
                             input logic p);
        int eg;
        int eid;
        eg  = (m_owner[d] >= 0) ? (1 << m_owner[d]) : 0;
        eid = (m_owner[d] >= 0) ? m_owner[d] : 0;
        chk($sformatf("model%0d.gnt", d), 32'(g), eg);
        chk($sformatf("model%0d.gnt_id", d), 32'(id), eid);
        chk($sformatf("model%0d.gnt_valid", d), 32'(v),
            (m_owner[d] >= 0) ? 1 : 0);
        chk($sformatf("model%0d.preempt", d), 32'(p), m_pre[d]);
    endtask

    // Compare current outputs, then advance the model with the
    // inputs that the next rising edge will sample.
    initial begin
        bit armed;
        armed = 1'b0;
        forever begin
            @(negedge clk);
            if (armed) begin
                model_cmp(0, bus8.gnt, bus8.gnt_id,
                          bus8.gnt_valid, bus8.preempt);
                model_cmp(1, bus2.gnt, bus2.gnt_id,
                          bus2.gnt_valid, bus2.preempt);
            end
            model_step(0);
            model_step(1);
            if (rst) armed = 1'b1;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int exp_seq [10];

    initial begin
        rst = 1'b1;
        req = 4'b0;
        cyc();
        cyc();
        chk("reset.gnt", 32'(bus8.gnt), 0);
        chk("reset.gnt_id", 32'(bus8.gnt_id), 0);
        chk("reset.valid", 32'(bus8.gnt_valid), 0);
        chk("reset.preempt", 32'(bus8.preempt), 0);

        rst = 1'b0;
        req = 4'b0101;
        cyc();
        chk("first.gnt", 32'(bus8.gnt), 4);
        chk("first.gnt_id", 32'(bus8.gnt_id), 2);
        chk("first.valid", 32'(bus8.gnt_valid), 1);
        rst = 1'b1;
        cyc();
        chk("midrst.gnt", 32'(bus8.gnt), 0);
        chk("midrst.valid", 32'(bus8.gnt_valid), 0);

        rst = 1'b0;
        cyc();
        chk("own2.gnt", 32'(bus8.gnt), 4);
        req = 4'b0001;
        cyc();
        chk("handover.gnt", 32'(bus8.gnt), 1);
        chk("handover.gnt_id", 32'(bus8.gnt_id), 0);
        chk("handover.valid", 32'(bus8.gnt_valid), 1);
        chk("handover.preempt", 32'(bus8.preempt), 0);
        req = 4'b0000;
        cyc();
        chk("release.valid", 32'(bus8.gnt_valid), 0);

        req = 4'b1001;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("hold3[%0d].gnt", i),
                32'(bus8.gnt), 8);
            chk($sformatf("hold3[%0d].pre", i),
                32'(bus8.preempt), 0);
        end
        cyc();
        chk("tmo.gnt", 32'(bus8.gnt), 1);
        chk("tmo.preempt", 32'(bus8.preempt), 1);
        cyc();
        chk("tmo.pulse_end", 32'(bus8.preempt), 0);
        repeat (6) cyc();
        chk("hold0.gnt", 32'(bus8.gnt), 1);
        cyc();
        chk("regrant3.gnt", 32'(bus8.gnt), 8);
        chk("regrant3.preempt", 32'(bus8.preempt), 1);

        req = 4'b0000;
        cyc();
        req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk($sformatf("solo[%0d].gnt", i),
                32'(bus8.gnt), 8);
            chk($sformatf("solo[%0d].pre", i),
                32'(bus8.preempt), 0);
        end

`ifdef PRIO_ARB_ROUND_ROBIN_EN
        exp_seq = '{3, 3, 2, 2, 1, 1, 0, 0, 3, 3};
`else
        exp_seq = '{3, 3, 2, 2, 3, 3, 2, 2, 3, 3};
`endif
        req = 4'b0000;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk($sformatf("seq[%0d].gnt_id", i),
                32'(bus2.gnt_id), exp_seq[i]);
        end

        for (int i = 0; i < 10000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 20)
                req = 4'($urandom);
            else if (r < 30)
                req[$urandom_range(0, 3)] = 1'b0;
            else if (r < 35)
                req = 4'b0;
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end

        rst = 1'b0;
        req = 4'b0;
        cyc();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prio_arbiter_4ch.md
Name: prio_arbiter_4ch

Overview:
- Four-requester arbiter that shares one downstream resource, such as an encoded bus slot, between channels 0..3.
- Winner selection uses the 4-to-2 priority-encode rule: highest index wins.
- Grants are registered and held until the owner releases its request or a hold timeout preempts it.
- Sits in front of any shared combinational datapath in the library and drives its select lines from the grant outputs.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one owner may hold the grant while others wait. 0 disables the timeout.
- CNT_W, 4, width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  4  request per channel, level-sensitive; bit i = channel i
- gnt  output  4  one-hot grant, registered
- gnt_id  output  2  encoded index of the granted channel, registered
- gnt_valid  output  1  high when any grant is active, registered
- preempt  output  1  single-cycle pulse, registered; high in the cycle a timeout-forced handover takes effect

Behaviour:
- Reset: rst=1 sampled at a clock edge gives gnt=0, gnt_id=0, gnt_valid=0, preempt=0, state=IDLE, hold_cnt=0, rr_ptr=0.
- Reset applies mid-grant too; the grant drops on the next edge.
- States:
  - IDLE: no owner.
  - BUSY: an owner holds the grant.
- IDLE -> BUSY:
  - When req != 0, the winner is registered. gnt/gnt_id/gnt_valid are visible one cycle after the req edge (latency 1).
  - req == 0 stays in IDLE with outputs 0.
- BUSY, owner's req stays high:
  - Hold the grant and increment hold_cnt, saturating.
- BUSY, owner's req drops (release):
  - If other requests are pending, the new winner is granted on the next edge. This is a back-to-back handover with no idle cycle, and hold_cnt is cleared.
  - Otherwise go to IDLE with outputs cleared.
- BUSY, timeout (MAX_HOLD != 0, hold_cnt == MAX_HOLD-1, and other requests pending):
  - On the next edge, grant the winner among the other channels, with the owner masked out.
  - preempt=1 for exactly that cycle; hold_cnt is cleared.
  - With no other requests pending the owner keeps the grant and hold_cnt saturates at MAX_HOLD-1.
- Winner selection (fixed priority, default):
  - Channel 3 > 2 > 1 > 0, independent of history.
  - Matches the priority-encode casez order.
- Simultaneous release and timeout: treat as a release; preempt stays 0.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_id == index(gnt) whenever gnt_valid=1.
  - gnt_valid == |gnt.
- A channel whose req rises in the same cycle another channel's req falls competes normally in that cycle's selection.
- No combinational path from req to any output.

Optional Feature:
- Macro: PRIO_ARB_ROUND_ROBIN_EN
- Defined:
  - rr_ptr (2 bits) is loaded with gnt_id on every new grant.
  - Search order after granting k: k-1, k-2, ... wrapping modulo 4, with k lowest.
  - rr_ptr resets to 0, so the first order is 3, 2, 1, 0, identical to fixed priority.
  - Applies to both release handover and timeout preemption.
- Undefined:
  - Fixed priority 3 > 2 > 1 > 0.
  - rr_ptr is not instantiated.

Decomposition:
- Package prio_arb_pkg holds:
  - localparam NUM_CH=4 and ID_W=2
  - enum arb_state_t {IDLE, BUSY}
  - a function returning a one-hot vector from a 2-bit id
- Sub-module prio_pick4 selects the winner combinationally.
  - Inputs: 4-bit masked request vector, 2-bit rotate offset.
  - Outputs: winner id, found flag.
  - Rotates the request vector, priority-encodes it 3-downto-0, then rotates the id back.
- Fixed-priority mode ties the offset to 0.

Test Plan:
- Reset, then req=4'b0101 held -> next cycle gnt=4'b0100, gnt_id=2, gnt_valid=1. Apply rst=1 mid-grant -> all outputs 0 next cycle.
- Owner 2 holds, req changes from 4'b0101 to 4'b0001 -> next cycle gnt=4'b0001, gnt_id=0, with no gnt_valid gap. Then req=0 -> gnt_valid=0 next cycle.
- MAX_HOLD=8, req=4'b1001 held -> ch3 granted 8 cycles, then gnt=4'b0001 with preempt=1 for one cycle. Without the RR macro, ch3 is regranted after ch0's hold expires.
- Timeout with only the owner requesting (req=4'b1000 for 20 cycles) -> gnt stays 4'b1000, preempt stays 0.
- PRIO_ARB_ROUND_ROBIN_EN, req=4'b1111 held, MAX_HOLD=2 -> grant sequence 3, 2, 1, 0, 3, each held 2 cycles.
- Random req for 10k cycles against a reference model -> one-hot, gnt_id/gnt_valid consistency and 1-cycle latency assertions pass.
